// File: rtl/wb_pipe_stage_if.sv
// Writeback pipe bundle: incoming RF write, outgoing RF write, forwarding lookups and occupancy.
// master drives the write/lookup side; slave is the pipe stage itself.
interface wb_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 1
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              stall;
  logic              flush;
  logic              writei;
  logic [DATA_W-1:0] wdatai;
  logic [REG_W-1:0]  rdreg;
  logic [DATA_W-1:0] wdatao;
  logic              writeo;
  logic [REG_W-1:0]  rdrego;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic              fwd1_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd2_data;
  logic [CNT_W-1:0]  inflight;

  modport master (
    output stall, flush, writei, wdatai, rdreg, rs1, rs2,
    input  wdatao, writeo, rdrego, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, inflight
  );

  modport slave (
    input  stall, flush, writei, wdatai, rdreg, rs1, rs2,
    output wdatao, writeo, rdrego, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, inflight
  );
endinterface

// File: rtl/wb_pipe_stage.sv
// DEPTH-stage writeback register (latency DEPTH edges) with flush > stall > advance control,
// x0 suppression, occupancy count and youngest-first forwarding lookups; stall holds every stage.
module wb_pipe_stage #(
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter int DEPTH         = 1,
  parameter int ZERO_SUPPRESS = 1
) (
  input logic            clk,
  input logic            rst,
  wb_pipe_stage_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_nxt;
  logic [REG_W-1:0]  rd_q  [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ins_vld;

  logic              f1_hit;
  logic [DATA_W-1:0] f1_data;
  logic              f2_hit;
  logic [DATA_W-1:0] f2_data;

  assign ins_vld = bus.writei && !((ZERO_SUPPRESS != 0) && (bus.rdreg == '0));

  // Occupancy after an advance, so the counter never lags the stage valids.
  always_comb begin
    vld_nxt    = '0;
    vld_nxt[0] = ins_vld;
    for (int i = 1; i < DEPTH; i++) begin
      vld_nxt[i] = vld_q[i-1];
    end
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(vld_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else if (bus.flush) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else if (!bus.stall) begin
      vld_q    <= vld_nxt;
      cnt_q    <= cnt_nxt;
      rd_q[0]  <= ins_vld ? bus.rdreg  : '0;
      dat_q[0] <= ins_vld ? bus.wdatai : '0;
      for (int i = 1; i < DEPTH; i++) begin
        rd_q[i]  <= rd_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // Walk oldest to youngest so the lowest-index match is the one left standing.
  always_comb begin
    f1_hit  = 1'b0;
    f1_data = '0;
    f2_hit  = 1'b0;
    f2_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && (bus.rs1 != '0) && (rd_q[i] == bus.rs1)) begin
        f1_hit  = 1'b1;
        f1_data = dat_q[i];
      end
      if (vld_q[i] && (bus.rs2 != '0) && (rd_q[i] == bus.rs2)) begin
        f2_hit  = 1'b1;
        f2_data = dat_q[i];
      end
    end
  end

  assign bus.writeo    = vld_q[DEPTH-1];
  assign bus.wdatao    = dat_q[DEPTH-1];
  assign bus.rdrego    = rd_q[DEPTH-1];
  assign bus.inflight  = cnt_q;
  assign bus.fwd1_hit  = f1_hit;
  assign bus.fwd1_data = f1_data;
  assign bus.fwd2_hit  = f2_hit;
  assign bus.fwd2_data = f2_data;
endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: three instances (DEPTH=1, DEPTH=3, DEPTH=1 without x0 suppression).
// Issued writes queue their expected RF write; a negedge monitor pops on every fresh output.
module tb_wb_pipe_stage;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t expq [3][$];
  bit   adv  [3];

  wb_pipe_stage_if #(.DATA_W(32), .REG_W(5), .DEPTH(1)) if1 ();
  wb_pipe_stage_if #(.DATA_W(32), .REG_W(5), .DEPTH(3)) if3 ();
  wb_pipe_stage_if #(.DATA_W(32), .REG_W(5), .DEPTH(1)) ifz ();

  wb_pipe_stage #(.DATA_W(32), .REG_W(5), .DEPTH(1), .ZERO_SUPPRESS(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  wb_pipe_stage #(.DATA_W(32), .REG_W(5), .DEPTH(3), .ZERO_SUPPRESS(1)) u3 (.clk(clk), .rst(rst), .bus(if3));
  wb_pipe_stage #(.DATA_W(32), .REG_W(5), .DEPTH(1), .ZERO_SUPPRESS(0)) uz (.clk(clk), .rst(rst), .bus(ifz));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drives the write inputs of one instance and records the write it must later produce.
  task automatic drive(input int id, input logic w, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    case (id)
      0: begin if1.writei = w; if1.rdreg = rd; if1.wdatai = d; end
      1: begin if3.writei = w; if3.rdreg = rd; if3.wdatai = d; end
      default: begin ifz.writei = w; ifz.rdreg = rd; ifz.wdatai = d; end
    endcase
    if (w && (rd != 5'd0 || id == 2)) begin
      e.rd = rd;
      e.d  = d;
      expq[id].push_back(e);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic mon(input int id, input bit a, input logic w, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    if (a && w) begin
      if (expq[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out%0d_spurious: got write rd=%0d data=%0h, expected no write", id, rd, d);
      end else begin
        e = expq[id].pop_front();
        chk($sformatf("out%0d_rd", id), 64'(rd), 64'(e.rd));
        chk($sformatf("out%0d_data", id), 64'(d), 64'(e.d));
      end
    end
  endtask

  always @(posedge clk) begin
    adv[0] = rst && !if1.stall && !if1.flush;
    adv[1] = rst && !if3.stall && !if3.flush;
    adv[2] = rst && !ifz.stall && !ifz.flush;
  end

  always @(negedge clk) begin
    mon(0, adv[0], if1.writeo, if1.rdrego, if1.wdatao);
    mon(1, adv[1], if3.writeo, if3.rdrego, if3.wdatao);
    mon(2, adv[2], ifz.writeo, ifz.rdrego, ifz.wdatao);
  end

  task automatic chk3(input string nm, input logic w, input logic [4:0] rd, input logic [31:0] d,
                      input logic [1:0] cnt);
    chk({nm, "_writeo"}, 64'(if3.writeo), 64'(w));
    chk({nm, "_rdrego"}, 64'(if3.rdrego), 64'(rd));
    chk({nm, "_wdatao"}, 64'(if3.wdatao), 64'(d));
    chk({nm, "_inflight"}, 64'(if3.inflight), 64'(cnt));
  endtask

  task automatic chkfwd(input string nm, input logic h1, input logic [31:0] d1,
                        input logic h2, input logic [31:0] d2);
    #1;
    chk({nm, "_fwd1_hit"}, 64'(if3.fwd1_hit), 64'(h1));
    chk({nm, "_fwd1_data"}, 64'(if3.fwd1_data), 64'(d1));
    chk({nm, "_fwd2_hit"}, 64'(if3.fwd2_hit), 64'(h2));
    chk({nm, "_fwd2_data"}, 64'(if3.fwd2_data), 64'(d2));
  endtask

  initial begin
    rst = 1'b0;
    {if1.stall, if1.flush, if1.writei, if1.wdatai, if1.rdreg, if1.rs1, if1.rs2} = '0;
    {if3.stall, if3.flush, if3.writei, if3.wdatai, if3.rdreg, if3.rs1, if3.rs2} = '0;
    {ifz.stall, ifz.flush, ifz.writei, ifz.wdatai, ifz.rdreg, ifz.rs1, ifz.rs2} = '0;
    cyc();
    cyc();
    chk("rst1_writeo", 64'(if1.writeo), 64'd0);
    chk("rst1_wdatao", 64'(if1.wdatao), 64'd0);
    chk("rst1_rdrego", 64'(if1.rdrego), 64'd0);
    chk("rst1_inflight", 64'(if1.inflight), 64'd0);
    chk3("rst3", 1'b0, 5'd0, 32'd0, 2'd0);
    rst = 1'b1;

    // DEPTH=1 basic write, then idle
    drive(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cyc();
    chk("d1_writeo", 64'(if1.writeo), 64'd1);
    chk("d1_rdrego", 64'(if1.rdrego), 64'd5);
    chk("d1_wdatao", 64'(if1.wdatao), 64'hDEAD_BEEF);
    chk("d1_inflight", 64'(if1.inflight), 64'd1);
    drive(0, 1'b0, 5'd0, 32'd0);
    cyc();
    chk("d1_idle_writeo", 64'(if1.writeo), 64'd0);
    chk("d1_idle_wdatao", 64'(if1.wdatao), 64'd0);
    chk("d1_idle_rdrego", 64'(if1.rdrego), 64'd0);

    // x0 suppressed vs. passed through
    drive(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cyc();
    chk("x0_sup_writeo", 64'(if1.writeo), 64'd0);
    chk("x0_sup_wdatao", 64'(if1.wdatao), 64'd0);
    chk("x0_sup_inflight", 64'(if1.inflight), 64'd0);
    drive(0, 1'b0, 5'd0, 32'd0);
    drive(2, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cyc();
    chk("x0_pass_writeo", 64'(ifz.writeo), 64'd1);
    chk("x0_pass_rdrego", 64'(ifz.rdrego), 64'd0);
    chk("x0_pass_wdatao", 64'(ifz.wdatao), 64'hFFFF_FFFF);
    chk("x0_pass_inflight", 64'(ifz.inflight), 64'd1);
    drive(2, 1'b0, 5'd0, 32'd0);
    cyc();
    chk("x0_pass_idle_writeo", 64'(ifz.writeo), 64'd0);

    // DEPTH=3 latency and stall
    drive(1, 1'b1, 5'd3, 32'h11);
    cyc();
    chk3("lat_e1", 1'b0, 5'd0, 32'd0, 2'd1);
    drive(1, 1'b1, 5'd4, 32'h22);
    cyc();
    chk3("lat_e2", 1'b0, 5'd0, 32'd0, 2'd2);
    drive(1, 1'b1, 5'd5, 32'h33);
    cyc();
    chk3("lat_e3", 1'b1, 5'd3, 32'h11, 2'd3);
    if3.stall = 1'b1;
    if3.writei = 1'b1; if3.rdreg = 5'd20; if3.wdatai = 32'h99;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk3($sformatf("stall%0d", k), 1'b1, 5'd3, 32'h11, 2'd3);
    end
    if3.stall = 1'b0;
    drive(1, 1'b0, 5'd0, 32'd0);
    cyc();
    chk3("unstall1", 1'b1, 5'd4, 32'h22, 2'd2);
    cyc();
    chk3("unstall2", 1'b1, 5'd5, 32'h33, 2'd1);
    cyc();
    chk3("drained", 1'b0, 5'd0, 32'd0, 2'd0);

    // Forwarding priority: S2={r7,A} S1={r9,B} S0={r7,C}
    drive(1, 1'b1, 5'd7, 32'hA); cyc();
    drive(1, 1'b1, 5'd9, 32'hB); cyc();
    drive(1, 1'b1, 5'd7, 32'hC); cyc();
    drive(1, 1'b0, 5'd0, 32'd0);
    if3.rs1 = 5'd7; if3.rs2 = 5'd9;
    chkfwd("fwd_young", 1'b1, 32'hC, 1'b1, 32'hB);
    if3.rs1 = 5'd0; if3.rs2 = 5'd12;
    chkfwd("fwd_x0_absent", 1'b0, 32'd0, 1'b0, 32'd0);
    if3.rs1 = 5'd9; if3.rs2 = 5'd9;
    chkfwd("fwd_same", 1'b1, 32'hB, 1'b1, 32'hB);
    cyc();
    if3.rs1 = 5'd9; if3.rs2 = 5'd7;
    chkfwd("fwd_outstage", 1'b1, 32'hB, 1'b1, 32'hC);

    // Flush beats stall; incoming write discarded
    drive(1, 1'b1, 5'd10, 32'h100); cyc();
    drive(1, 1'b1, 5'd11, 32'h200); cyc();
    drive(1, 1'b1, 5'd12, 32'h300); cyc();
    chk("flush_pre_inflight", 64'(if3.inflight), 64'd3);
    if3.flush = 1'b1; if3.stall = 1'b1;
    if3.writei = 1'b1; if3.rdreg = 5'd15; if3.wdatai = 32'h555;
    expq[1].delete();
    if3.rs1 = 5'd10; if3.rs2 = 5'd12;
    cyc();
    chk3("flush", 1'b0, 5'd0, 32'd0, 2'd0);
    chkfwd("flush", 1'b0, 32'd0, 1'b0, 32'd0);
    if3.flush = 1'b0; if3.stall = 1'b0;
    drive(1, 1'b0, 5'd0, 32'd0);
    if3.rs1 = 5'd15;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("flush_after%0d_writeo", k), 64'(if3.writeo), 64'd0);
    end
    chkfwd("flush_after", 1'b0, 32'd0, 1'b0, 32'd0);

    // Async reset between edges, then refill
    drive(1, 1'b1, 5'd1, 32'h1); cyc();
    drive(1, 1'b1, 5'd2, 32'h2); cyc();
    drive(1, 1'b1, 5'd3, 32'h3); cyc();
    chk3("arst_pre", 1'b1, 5'd1, 32'h1, 2'd3);
    drive(1, 1'b0, 5'd0, 32'd0);
    if3.rs1 = 5'd2; if3.rs2 = 5'd3;
    #2 rst = 1'b0;
    #1;
    chk3("arst", 1'b0, 5'd0, 32'd0, 2'd0);
    chkfwd("arst", 1'b0, 32'd0, 1'b0, 32'd0);
    for (int q = 0; q < 3; q++) expq[q].delete();
    cyc();
    rst = 1'b1;
    drive(1, 1'b1, 5'd6, 32'h66); cyc();
    drive(1, 1'b1, 5'd8, 32'h88); cyc();
    drive(1, 1'b0, 5'd0, 32'd0); cyc();
    chk3("refill", 1'b1, 5'd6, 32'h66, 2'd2);
    cyc();
    cyc();
    chk3("refill_drain", 1'b0, 5'd0, 32'd0, 2'd0);

    for (int q = 0; q < 3; q++) begin
      chk($sformatf("q%0d_left", q), 64'(expq[q].size()), 64'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
- Parametrised writeback pipeline register that carries a register-file write (data, destination index, write enable) from the execute side to the register file.
- Depth is configurable; DEPTH=1 is a single EX/WB register.
- Adds stall and flush control, suppression of writes to x0, an in-flight write counter, and two forwarding lookup ports. Decode/execute use these ports to bypass pending writes still in the pipe.

Parameters:
- DATA_W, 32, width of the write data.
- REG_W, 5, width of the register index.
- DEPTH, 1, number of pipeline stages between input and output (legal range 1..8).
- ZERO_SUPPRESS, 1, when 1 a write to register index 0 is inserted as invalid.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  hold all stages when 1.
- flush  input  1  invalidate all stages when 1.
- writei  input  1  write enable of the incoming entry.
- wdatai  input  DATA_W  incoming write data.
- rdreg  input  REG_W  incoming destination index.
- wdatao  output  DATA_W  write data to the register file, registered.
- writeo  output  1  write enable to the register file, registered.
- rdrego  output  REG_W  destination index to the register file, registered.
- rs1  input  REG_W  forwarding lookup address 1.
- rs2  input  REG_W  forwarding lookup address 2.
- fwd1_hit  output  1  a valid in-flight write to rs1 exists.
- fwd1_data  output  DATA_W  youngest in-flight data for rs1; 0 on miss.
- fwd2_hit  output  1  same as fwd1_hit, for rs2.
- fwd2_data  output  DATA_W  same as fwd1_data, for rs2.
- inflight  output  $clog2(DEPTH+1)  count of valid stages, registered.

Behaviour:
- Storage: stages S0..S(DEPTH-1). Each stage holds {valid, rd, data}. S0 is youngest; S(DEPTH-1) drives wdatao/rdrego/writeo.
- Invariant: a stage with valid=0 holds rd=0 and data=0.
- Reset (rst=0, asynchronous, any time including mid-operation):
  - every stage is cleared to valid=0, rd=0, data=0;
  - writeo=0, wdatao=0, rdrego=0, inflight=0;
  - the reset takes effect immediately, with no clock edge required.
- Insert qualifier: ins_valid = writei AND NOT (ZERO_SUPPRESS AND rdreg==0). When ins_valid=0, S0 loads the zero entry.
- Each rising edge, priority order is flush > stall > advance:
  - flush=1: all stages load the zero entry. The incoming entry is discarded. flush=1 with stall=1 still flushes.
  - stall=1, flush=0: all stages hold and the input is ignored. Outputs remain stable, so the register file sees the same write repeatedly. A repeated write is idempotent and permitted.
  - otherwise: S0 <= {ins_valid, rdreg or 0, wdatai or 0}, and S(i) <= S(i-1) for i=1..DEPTH-1.
- Latency: an entry presented at edge k appears on writeo/wdatao/rdrego after edge k+DEPTH-1. That means DEPTH edges including the capture edge, excluding stall cycles.
- writeo = S(DEPTH-1).valid; wdatao/rdrego are that stage's data/rd, so all three are zero whenever writeo=0.
- inflight: registered count of valid stages, updated on the same edge as the stages, so it always equals the current number of valid stages. It is 0 after flush or reset and saturates naturally at DEPTH.
- Forwarding (combinational on current stage contents, not on the inputs):
  - fwdN_hit=1 iff rsN!=0 and some valid stage has rd==rsN.
  - fwdN_data is taken from the lowest-index (youngest) matching stage.
  - rsN==0 always gives hit=0, data=0.
  - The output stage is included in the search.
- Two lookup ports are independent; rs1==rs2 gives identical results.

Test Plan:
- Reset/basic, DEPTH=1: hold rst=0 → all outputs 0. Release rst, drive writei=1, rdreg=5, wdatai=0xDEADBEEF for one edge → after that edge writeo=1, rdrego=5, wdatao=0xDEADBEEF. Drive writei=0 next edge → writeo=0, wdatao=0, rdrego=0.
- Latency and stall, DEPTH=3: insert {r3=0x11}, {r4=0x22}, {r5=0x33} on consecutive edges → r3 appears on the outputs after the 3rd edge. Assert stall for 2 edges → outputs hold r3/0x11 and inflight stays 3. Deassert stall → r4 then r5 follow on the next edges.
- Flush priority, DEPTH=3: fill 3 valid entries, then assert flush=1 and stall=1 together with writei=1 → after the edge, writeo=0, inflight=0, and both fwd hits are 0. The incoming entry never appears.
- x0 suppression: writei=1, rdreg=0, wdatai=0xFFFF_FFFF with ZERO_SUPPRESS=1 → the entry becomes invalid, writeo stays 0 and inflight does not increment. Repeat with ZERO_SUPPRESS=0 → writeo=1, rdrego=0.
- Forwarding priority, DEPTH=3:
  - pipe holds S2={r7,0xA}, S1={r9,0xB}, S0={r7,0xC}; rs1=7, rs2=9 → fwd1_hit=1, fwd1_data=0xC; fwd2_hit=1, fwd2_data=0xB.
  - rs1=0 → fwd1_hit=0, fwd1_data=0.
  - rs2=12 (absent) → fwd2_hit=0.
- Async reset mid-operation: with 3 valid entries, drop rst=0 between clock edges → outputs and inflight go to 0 before the next edge. Release rst → the pipe refills normally from empty.
